// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer feeding the RS / LSB, with CDB snooping on queued operands.
// Optional same-cycle bypass of an empty buffer: define DISPATCH_BUF_BYPASS_EN.
module dispatch_buffer #(
   parameter int DEPTH    = 4,
   parameter int CDB_NUM  = 2,
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32,
   parameter int OPENUM_W = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic                          misbranch_flag,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_is_ls,
   input  logic [OPENUM_W-1:0]           in_openum,
   input  logic [DATA_W-1:0]             in_V1,
   input  logic [DATA_W-1:0]             in_V2,
   input  logic [ROB_ID_W-1:0]           in_Q1,
   input  logic [ROB_ID_W-1:0]           in_Q2,
   input  logic [DATA_W-1:0]             in_pc,
   input  logic [DATA_W-1:0]             in_imm,
   input  logic [ROB_ID_W-1:0]           in_rob_id,
   input  logic [CDB_NUM-1:0]            cdb_valid,
   input  logic [CDB_NUM*ROB_ID_W-1:0]   cdb_rob_id,
   input  logic [CDB_NUM*DATA_W-1:0]     cdb_result,
   input  logic                          rs_ready,
   input  logic                          lsb_ready,
   output logic                          rs_valid,
   output logic                          lsb_valid,
   output logic [OPENUM_W-1:0]           out_openum,
   output logic [DATA_W-1:0]             out_V1,
   output logic [DATA_W-1:0]             out_V2,
   output logic [ROB_ID_W-1:0]           out_Q1,
   output logic [ROB_ID_W-1:0]           out_Q2,
   output logic [DATA_W-1:0]             out_pc,
   output logic [DATA_W-1:0]             out_imm,
   output logic [ROB_ID_W-1:0]           out_rob_id,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]    FULL     = CNT_W'(DEPTH);
   localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;

   typedef struct packed {
      logic                is_ls;
      logic [OPENUM_W-1:0] openum;
      logic [DATA_W-1:0]   v1;
      logic [DATA_W-1:0]   v2;
      logic [ROB_ID_W-1:0] q1;
      logic [ROB_ID_W-1:0] q2;
      logic [DATA_W-1:0]   pc;
      logic [DATA_W-1:0]   imm;
      logic [ROB_ID_W-1:0] rob_id;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [DEPTH-1:0]   valid;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   entry_t             in_entry;
   entry_t             in_woken;
   entry_t             head_woken;
   entry_t             out_e;
   logic               active;
   logic               bypass;
   logic               enq;
   logic               deq;

   // Resolve both operands against the CDB; iterating downward lets the lowest channel win.
   function automatic entry_t wake(input entry_t e,
                                   input logic [CDB_NUM-1:0]          cv,
                                   input logic [CDB_NUM*ROB_ID_W-1:0] cid,
                                   input logic [CDB_NUM*DATA_W-1:0]   cres);
      entry_t r;
      r = e;
      for (int k = CDB_NUM - 1; k >= 0; k--) begin
         if (cv[k] && e.q1 != ZERO_ROB && cid[k*ROB_ID_W +: ROB_ID_W] == e.q1) begin
            r.v1 = cres[k*DATA_W +: DATA_W];
            r.q1 = ZERO_ROB;
         end
         if (cv[k] && e.q2 != ZERO_ROB && cid[k*ROB_ID_W +: ROB_ID_W] == e.q2) begin
            r.v2 = cres[k*DATA_W +: DATA_W];
            r.q2 = ZERO_ROB;
         end
      end
      return r;
   endfunction

   assign active   = rst && rdy && !misbranch_flag;
   assign in_ready = active && (count != FULL);

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      in_entry        = '0;
      in_entry.is_ls  = in_is_ls;
      in_entry.openum = in_openum;
      in_entry.v1     = in_V1;
      in_entry.v2     = in_V2;
      in_entry.q1     = in_Q1;
      in_entry.q2     = in_Q2;
      in_entry.pc     = in_pc;
      in_entry.imm    = in_imm;
      in_entry.rob_id = in_rob_id;
   end

   assign in_woken   = wake(in_entry, cdb_valid, cdb_rob_id, cdb_result);
   assign head_woken = wake(mem[head], cdb_valid, cdb_rob_id, cdb_result);

`ifdef DISPATCH_BUF_BYPASS_EN
   assign bypass = in_valid && in_ready && (count == '0) && (in_is_ls ? lsb_ready : rs_ready);
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      out_e     = '0;
      rs_valid  = 1'b0;
      lsb_valid = 1'b0;
      if (active) begin
         if (count != '0) begin
            out_e     = head_woken;
            rs_valid  = !head_woken.is_ls;
            lsb_valid = head_woken.is_ls;
         end else if (bypass) begin
            out_e     = in_woken;
            rs_valid  = !in_is_ls;
            lsb_valid = in_is_ls;
         end
      end
   end

   assign enq = in_valid && in_ready && !bypass;
   assign deq = (count != '0) && ((rs_valid && rs_ready) || (lsb_valid && lsb_ready));

   assign out_openum = out_e.openum;
   assign out_V1     = out_e.v1;
   assign out_V2     = out_e.v2;
   assign out_Q1     = out_e.q1;
   assign out_Q2     = out_e.q2;
   assign out_pc     = out_e.pc;
   assign out_imm    = out_e.imm;
   assign out_rob_id = out_e.rob_id;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else if (rdy) begin
         if (misbranch_flag) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
         end else begin
            if (enq) begin
               valid[tail] <= 1'b1;
               tail        <= tail + 1'b1;
            end
            if (deq) begin
               valid[head] <= 1'b0;
               head        <= head + 1'b1;
            end
            case ({enq, deq})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // NOTE: payload storage carries no reset; the valid bits and pointers define what is live.
   always_ff @(posedge clk) begin
      if (active) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) mem[i] <= wake(mem[i], cdb_valid, cdb_rob_id, cdb_result);
         end
         if (enq) mem[tail] <= in_woken;
      end
   end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Scoreboard bench for dispatch_buffer: expected packets are queued on accept and
// compared field by field when the DUT issues them. Honours DISPATCH_BUF_BYPASS_EN.
module tb_dispatch_buffer;

   localparam int DEPTH = 4, CDB_NUM = 2, RW = 4, DW = 32, OW = 6;

`ifdef DISPATCH_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      bit            is_ls;
      logic [OW-1:0] openum;
      logic [DW-1:0] v1, v2, pc, imm;
      logic [RW-1:0] q1, q2, rob_id;
   } pkt_t;

   logic clk, rst, rdy, misbranch_flag, in_valid, in_ready, in_is_ls;
   logic [OW-1:0] in_openum, out_openum;
   logic [DW-1:0] in_V1, in_V2, in_pc, in_imm, out_V1, out_V2, out_pc, out_imm;
   logic [RW-1:0] in_Q1, in_Q2, in_rob_id, out_Q1, out_Q2, out_rob_id;
   logic [CDB_NUM-1:0]    cdb_valid;
   logic [CDB_NUM*RW-1:0] cdb_rob_id;
   logic [CDB_NUM*DW-1:0] cdb_result;
   logic rs_ready, lsb_ready, rs_valid, lsb_valid;
   logic [$clog2(DEPTH+1)-1:0] count;

   int   total = 0;
   int   bad   = 0;
   pkt_t sb[$];

   dispatch_buffer #(.DEPTH(DEPTH), .CDB_NUM(CDB_NUM), .ROB_ID_W(RW), .DATA_W(DW), .OPENUM_W(OW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_ls(in_is_ls), .in_openum(in_openum),
      .in_V1(in_V1), .in_V2(in_V2), .in_Q1(in_Q1), .in_Q2(in_Q2), .in_pc(in_pc), .in_imm(in_imm),
      .in_rob_id(in_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
      .rs_ready(rs_ready), .lsb_ready(lsb_ready), .rs_valid(rs_valid), .lsb_valid(lsb_valid),
      .out_openum(out_openum), .out_V1(out_V1), .out_V2(out_V2), .out_Q1(out_Q1), .out_Q2(out_Q2),
      .out_pc(out_pc), .out_imm(out_imm), .out_rob_id(out_rob_id), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic pkt_t mk(input logic [RW-1:0] rob, input bit ls,
                               input logic [RW-1:0] q1, input logic [RW-1:0] q2);
      pkt_t p;
      p.is_ls  = ls;
      p.openum = OW'(rob) + 6'd1;
      p.v1     = {16'hA000, 12'h000, rob};
      p.v2     = {16'hB000, 12'h000, rob};
      p.pc     = 32'h1000 + 32'(rob) * 4;
      p.imm    = {28'h0, rob} ^ 32'h55;
      p.q1     = q1;
      p.q2     = q2;
      p.rob_id = rob;
      return p;
   endfunction

   // Reference CDB resolution: first matching channel (lowest index) supplies the value.
   function automatic pkt_t model_wake(input pkt_t p);
      pkt_t r;
      bit   f1, f2;
      r = p; f1 = 0; f2 = 0;
      for (int k = 0; k < CDB_NUM; k++) begin
         if (!f1 && p.q1 != 0 && cdb_valid[k] && cdb_rob_id[k*RW +: RW] == p.q1) begin
            r.v1 = cdb_result[k*DW +: DW]; r.q1 = '0; f1 = 1;
         end
         if (!f2 && p.q2 != 0 && cdb_valid[k] && cdb_rob_id[k*RW +: RW] == p.q2) begin
            r.v2 = cdb_result[k*DW +: DW]; r.q2 = '0; f2 = 1;
         end
      end
      return r;
   endfunction

   task automatic send(input pkt_t p, input bit accept);
      in_valid  = 1'b1;
      in_is_ls  = p.is_ls;
      in_openum = p.openum;
      in_V1 = p.v1; in_V2 = p.v2; in_Q1 = p.q1; in_Q2 = p.q2;
      in_pc = p.pc; in_imm = p.imm; in_rob_id = p.rob_id;
      if (accept) sb.push_back(p);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic set_cdb(input logic [1:0] v, input logic [RW-1:0] id0, input logic [DW-1:0] r0,
                          input logic [RW-1:0] id1, input logic [DW-1:0] r1);
      cdb_valid  = v;
      cdb_rob_id = {id1, id0};
      cdb_result = {r1, r0};
   endtask

   task automatic take(input bit ls);
      pkt_t e;
      if (sb.size() == 0) begin
         check("issue_with_empty_scoreboard", 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check("iss_unit",   ls,         e.is_ls);
      check("iss_rob_id", out_rob_id, e.rob_id);
      check("iss_openum", out_openum, e.openum);
      check("iss_Q1",     out_Q1,     e.q1);
      check("iss_Q2",     out_Q2,     e.q2);
      check("iss_V1",     out_V1,     e.v1);
      check("iss_V2",     out_V2,     e.v2);
      check("iss_pc",     out_pc,     e.pc);
      check("iss_imm",    out_imm,    e.imm);
   endtask

   // One cycle: settle, update the model with this cycle's CDB, score any issue, advance.
   task automatic tick();
      #1;
      if (rst && rdy && !misbranch_flag)
         foreach (sb[i]) sb[i] = model_wake(sb[i]);
      if (rs_valid && rs_ready)   take(1'b0);
      if (lsb_valid && lsb_ready) take(1'b1);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; misbranch_flag = 1'b0; rs_ready = 1'b0; lsb_ready = 1'b0;
      send(mk(4'd1, 1'b0, 4'd0, 4'd0), 1'b0);
      set_cdb(2'b00, '0, '0, '0, '0);
      #1;
      check("rst_in_ready",  in_ready,  1'b0);
      check("rst_rs_valid",  rs_valid,  1'b0);
      check("rst_lsb_valid", lsb_valid, 1'b0);
      check("rst_out_rob",   out_rob_id, '0);
      check("rst_out_V1",    out_V1,    '0);
      @(posedge clk); @(negedge clk);
      check("rst_count", count, '0);
      idle();
      rst = 1'b1;

      // Fill without drain, reject the fifth, then drain in order.
      for (int r = 1; r <= 4; r++) begin
         send(mk(4'(r), 1'b0, 4'd0, 4'd0), 1'b1);
         tick();
      end
      idle();
      #1;
      check("full_count",    count,    4);
      check("full_in_ready", in_ready, 1'b0);
      send(mk(4'd5, 1'b0, 4'd0, 4'd0), 1'b0);
      #1 check("full_reject", in_ready, 1'b0);
      tick();
      idle();
      rs_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("drain_rs_valid", rs_valid, 1'b1);
         tick();
      end
      #1 check("drained_count", count, 0);
      rs_ready = 1'b0;

      // Wakeup while queued, then duplicate-match priority.
      send(mk(4'd5, 1'b0, 4'd3, 4'd9), 1'b1);
      tick();
      idle();
      set_cdb(2'b10, 4'd0, 32'h0, 4'd3, 32'hDEAD);
      tick();
      set_cdb(2'b11, 4'd9, 32'h111, 4'd9, 32'h222);
      tick();
      set_cdb(2'b00, '0, '0, '0, '0);
      #1 check("wake_count", count, 1);
      rs_ready = 1'b1;
      #1 check("wake_stored_V1", out_V1, 32'hDEAD);
      tick();
      rs_ready = 1'b0;

      // Same-cycle forward on head, then wakeup of the incoming packet.
      send(mk(4'd6, 1'b0, 4'd0, 4'd5), 1'b1);
      tick();
      idle();
      rs_ready = 1'b1;
      set_cdb(2'b01, 4'd5, 32'h1234, 4'd0, 32'h0);
      tick();
      set_cdb(2'b00, '0, '0, '0, '0);
      rs_ready = 1'b0;
      send(mk(4'd7, 1'b0, 4'd4, 4'd0), 1'b1);
      set_cdb(2'b01, 4'd4, 32'h4444, 4'd0, 32'h0);
      tick();
      idle();
      set_cdb(2'b00, '0, '0, '0, '0);
      rs_ready = 1'b1;
      tick();
      rs_ready = 1'b0;

      // Head-of-line blocking: LSB head stalls an RS packet behind it.
      rs_ready = 1'b1; lsb_ready = 1'b0;
      send(mk(4'd8, 1'b1, 4'd0, 4'd0), 1'b1);
      tick();
      send(mk(4'd9, 1'b0, 4'd0, 4'd0), 1'b1);
      tick();
      idle();
      for (int i = 0; i < 2; i++) begin
         #1;
         check("hol_rs_blocked", rs_valid,  1'b0);
         check("hol_lsb_wait",   lsb_valid, 1'b1);
         tick();
      end
      lsb_ready = 1'b1;
      tick();
      #1 check("hol_rs_next", rs_valid, 1'b1);
      tick();
      rs_ready = 1'b0; lsb_ready = 1'b0;

      // Flush with three queued entries, then a clean enqueue.
      for (int r = 13; r <= 15; r++) begin
         send(mk(4'(r), 1'b0, 4'd0, 4'd0), 1'b1);
         tick();
      end
      idle();
      #1 check("preflush_count", count, 3);
      misbranch_flag = 1'b1; rs_ready = 1'b1; lsb_ready = 1'b1;
      send(mk(4'd12, 1'b0, 4'd0, 4'd0), 1'b0);
      #1;
      check("flush_in_ready", in_ready, 1'b0);
      check("flush_rs_valid", rs_valid, 1'b0);
      sb.delete();
      tick();
      misbranch_flag = 1'b0;
      idle();
      #1;
      check("postflush_count",     count,     0);
      check("postflush_rs_valid",  rs_valid,  1'b0);
      check("postflush_lsb_valid", lsb_valid, 1'b0);
      send(mk(4'd10, 1'b0, 4'd0, 4'd6), 1'b1);
      tick();
      idle();
      tick();
      check("postflush_drained", 64'(sb.size()), 64'd0);

      // Bypass behaviour on an empty buffer.
      send(mk(4'd11, 1'b0, 4'd0, 4'd0), 1'b1);
      #1 check("byp_rs_valid_same_cycle", rs_valid, BYP);
      tick();
      idle();
      #1 check("byp_count", count, BYP ? 0 : 1);
      tick();
      #1 check("byp_final_count", count, 0);
      rs_ready = 1'b0; lsb_ready = 1'b0;

      // rdy low freezes state, blocks handshakes and ignores the CDB.
      send(mk(4'd12, 1'b0, 4'd2, 4'd0), 1'b1);
      tick();
      rdy = 1'b0; rs_ready = 1'b1;
      set_cdb(2'b01, 4'd2, 32'h2222, 4'd0, 32'h0);
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_rs_valid", rs_valid, 1'b0);
      tick();
      #1 check("stall_count", count, 1);
      rdy = 1'b1;
      idle();
      set_cdb(2'b00, '0, '0, '0, '0);
      tick();
      rs_ready = 1'b0;

      check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
